dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The parameter DEPTH SHALL default to 1024 and set the storage size in 32-bit words; it SHALL be a power of two.
REQ-002 The parameter WAIT SHALL default to 2 and set the accept-to-done latency in cycles; its legal range SHALL be 1..15.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-low.
REQ-005 Port dmem_read  input  1: read request, held by the initiator until mem_done.
REQ-006 Port dmem_write  input  1: write request, held by the initiator until mem_done.
REQ-007 Port mem_addr  input  32: byte address; bits [1:0] SHALL be ignored.
REQ-008 Port mem_wdata  input  32: store data.
REQ-009 Port mem_rdata  output  32: load data.
REQ-010 Port mem_done  output  1: one-cycle completion pulse.
REQ-011 Port mem_busy  output  1: high while a request is in progress.
REQ-012 Port mem_err  output  1: out-of-range flag, qualified by mem_done.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 In IDLE, if dmem_read or dmem_write is high at a rising edge, the block SHALL capture the word index, the write data and the operation, load the wait counter with WAIT-1 and enter BUSY.
REQ-015 In BUSY, at each edge where a request is still high, the counter SHALL decrement; at the edge where it is 0, the block SHALL enter DONE and perform the access.
REQ-016 With a request accepted at edge k, mem_done SHALL be high for exactly the cycle following edge k+WAIT.
REQ-017 DONE SHALL return to IDLE unconditionally, ignoring request inputs at that edge, so that a held request completes exactly once.
REQ-018 A write SHALL commit the captured data to the captured index at the DONE-entry edge.
REQ-019 A read SHALL load mem_rdata at the DONE-entry edge; mem_rdata SHALL hold its value until the next completion.
REQ-020 If dmem_read and dmem_write are both high at acceptance, the block SHALL perform a write, and mem_rdata SHALL return the word as it was before the write.
REQ-021 Address and data changes after acceptance SHALL be ignored.
REQ-022 If both requests are low at an edge while in BUSY, the block SHALL abort to IDLE with no write and no mem_done.
REQ-023 mem_busy SHALL be high in BUSY and in DONE, and low in IDLE.
REQ-024 A read of a never-written location SHALL return an undefined value; the storage array SHALL not be reset.

Reset
REQ-025 When rst is low, the block SHALL asynchronously force the state to IDLE, the counter to 0, mem_rdata to 0, mem_done to 0, mem_busy to 0 and mem_err to 0.
REQ-026 A reset during BUSY SHALL abort the request; a pending write SHALL not commit.
REQ-027 After rst rises, the first acceptance SHALL be possible at the next rising edge.

Configuration
REQ-028 The macro DMEM_ADDR_CHECK_EN SHALL select range checking.
REQ-029 When DMEM_ADDR_CHECK_EN is defined, a captured word index of DEPTH or more SHALL complete normally in timing, suppress the write, return mem_rdata = 0, and drive mem_err high together with mem_done.
REQ-030 When DMEM_ADDR_CHECK_EN is undefined, the index SHALL wrap modulo DEPTH and mem_err SHALL be tied to 0.

Verification
REQ-031 Write then read (WAIT=2): write 0xDEADBEEF to 0x40; mem_done SHALL rise 2 edges after acceptance; reading 0x40 SHALL return mem_rdata = 0xDEADBEEF with mem_done high for one cycle.
REQ-032 Held request: hold dmem_read through DONE and one further cycle; exactly one mem_done pulse SHALL occur, and re-acceptance SHALL occur at the edge after DONE.
REQ-033 Abort: drop dmem_write after 1 cycle in BUSY with 0x11111111 to 0x80; there SHALL be no mem_done, and a subsequent read of 0x80 SHALL return the prior value.
REQ-034 Reset mid-write: pull rst low during BUSY; all outputs SHALL be 0 immediately, and the target word SHALL be unchanged.
REQ-035 Range check: with DMEM_ADDR_CHECK_EN defined and DEPTH=1024, read 0x1000; the response SHALL be mem_err=1, mem_rdata=0. Without the macro, the same read SHALL return the word at 0x0.
REQ-036 Simultaneous read and write: word 0x10 holds 0xA5A5A5A5; write 0x5A5A5A5A to 0x10 with both requests high; mem_rdata SHALL equal 0xA5A5A5A5, and a subsequent read SHALL return 0x5A5A5A5A.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder; DMEM_ADDR_CHECK_EN enables out-of-range detection
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        cap_rd;
  logic        cap_wr;
  logic [31:0] cap_wdata;
  logic        req;
  logic        accept;
  logic        finish;
  logic        in_range;
  logic [AW-1:0] mem_idx;

  // Storage is deliberately left without reset.
  logic [31:0] mem [DEPTH];

  // Byte-offset bits (and, without range checking, the bits above the index) carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr;

`ifdef DMEM_ADDR_CHECK_EN
  // Full word index is kept so that indices past the array can be flagged.
  logic [29:0] cap_idx;
  assign in_range = (cap_idx < 30'(DEPTH));
  assign mem_idx  = cap_idx[AW-1:0];
`else
  // Index wraps modulo DEPTH; only the low bits are ever needed.
  logic [AW-1:0] cap_idx;
  assign in_range = 1'b1;
  assign mem_idx  = cap_idx;
  assign mem_err  = 1'b0;
`endif

  assign req      = dmem_read | dmem_write;
  assign mem_busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: accept, count down while held, finish or abort; DONE always falls back to IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_wdata <= 32'd0;
      cap_idx   <= '0;
      mem_rdata <= 32'd0;
      mem_done  <= 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
      mem_err   <= 1'b0;
`endif
    end else begin
      mem_done <= finish;
`ifdef DMEM_ADDR_CHECK_EN
      mem_err  <= finish & ~in_range;
`endif
      if (accept) begin
        cnt       <= 4'(WAIT - 1);
        cap_rd    <= dmem_read;
        cap_wr    <= dmem_write;
        cap_wdata <= mem_wdata;
`ifdef DMEM_ADDR_CHECK_EN
        cap_idx   <= mem_addr[31:2];
`else
        cap_idx   <= mem_addr[AW+1:2];
`endif
      end else if ((state == BUSY) && req && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      // A combined read/write returns the word as it stood before this edge's write.
      if (finish && cap_rd) begin
        mem_rdata <= in_range ? mem[mem_idx] : 32'd0;
      end
    end
  end

  // Write commit at the DONE-entry edge only.
  always_ff @(posedge clk) begin
    if (finish && cap_wr && in_range) begin
      mem[mem_idx] <= cap_wdata;
    end
  end

endmodule
